cpa_nibble_sequencer: RTL and testbench
=======================================

Name: cpa_nibble_sequencer

Overview:
- Multi-cycle controller that performs WIDTH-bit add/subtract by time-sharing one external 4-bit carry-propagate adder (CPA), one nibble per clock, LSB nibble first.
- Registers the carry between nibbles, assembles the result, and presents it through a valid/ready handshake.
- Sits between a requester, e.g. an ALU front end, and the shared 4-bit CPA, which stays purely combinational outside this block.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, number of nibble steps (derived, not overridable).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when in_ready=1.
- sub  in  1  0 = A+B+cin, 1 = A-B (cin ignored); sampled with start.
- cin  in  1  carry in for add; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- in_ready  out  1  high only in IDLE.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB nibble.
- ovf  out  1  two's-complement overflow.
- cpa_a  out  4  nibble of A to the CPA.
- cpa_b  out  4  nibble of effective B to the CPA.
- cpa_cin  out  1  carry into the CPA.
- cpa_s  in  4  CPA sum.
- cpa_cout  in  1  CPA carry out.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n). rst_n=0 forces, immediately:
  - state=IDLE.
  - All registers 0, so sum=0, cout=0, ovf=0, out_valid=0, in_ready=1.
  - cpa_a=0, cpa_b=0, cpa_cin=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On a clock edge with start=1:
    - a_reg<=a.
    - b_reg<=(sub ? ~b : b).
    - carry<=(sub ? 1 : cin).
    - idx<=0, sum_reg<=0.
    - Go to RUN.
  - start=0 keeps the block in IDLE.
- RUN:
  - Combinational outputs: cpa_a=a_reg[4*idx+3:4*idx], cpa_b=b_reg[4*idx+3:4*idx], cpa_cin=carry.
  - Each edge:
    - sum_reg nibble idx<=cpa_s.
    - carry<=cpa_cout.
    - idx<=idx+1.
  - On the edge with idx=NIB-1:
    - cout<=cpa_cout.
    - ovf<=(a_reg[WIDTH-1]==b_reg[WIDTH-1]) && (cpa_s[3]!=a_reg[WIDTH-1]).
    - Go to DONE; idx does not wrap into another RUN.
- DONE:
  - out_valid=1; sum, cout and ovf hold stable.
  - Edge with out_ready=1 goes to IDLE; out_valid drops and in_ready rises in the same cycle.
  - out_ready=0 holds DONE indefinitely.
  - No bypass: a new request can be accepted at the earliest one cycle after the result handshake.
- Latency: out_valid rises exactly NIB edges after the accepting edge (4 for WIDTH=16). Back-to-back throughput is one result per NIB+2 cycles.
- CPA outputs outside RUN: cpa_a, cpa_b and cpa_cin are driven 0 in IDLE and DONE.
- sum, cout and ovf after handshake: keep the last result until the next RUN overwrites them.
- start outside IDLE: ignored and not queued; the latched operands do not change.
- out_ready outside DONE: ignored.
- Subtraction: implemented as A+~B+1.
  - cout=1 means no borrow.
  - ovf uses the effective (inverted) B MSB.
- Reset mid-RUN or mid-DONE: aborts immediately to the reset values above; the partial result is discarded.

Test Plan:
1. Add, WIDTH=16, sub=0, cin=0: a=0x1234, b=0x4321 -> after 4 edges out_valid=1, sum=0x5555, cout=0, ovf=0. During RUN, cpa_a steps 4,3,2,1 and cpa_b steps 1,2,3,4.
2. Carry ripple across all nibbles: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. cpa_cin=1 on nibbles 1..3. Second case: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
3. Signed overflow and subtract:
   - a=0x7FFF, b=0x0001 add -> sum=0x8000, ovf=1, cout=0.
   - sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0.
   - sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1, cout=1.
4. Backpressure and ignored start:
   - Hold out_ready=0 for 3 cycles after out_valid, with start=1 and new operands pulsed during RUN and DONE.
   - Required: result held, in_ready=0, the pulsed request is not executed.
   - Then raise out_ready -> IDLE next edge. A start on the following edge is accepted.
5. Reset mid-operation: assert rst_n=0 asynchronously after 2 RUN edges -> sum=0, out_valid=0, in_ready=1, cpa_* outputs 0, with no clock required. A new request after release completes normally with correct values.
6. Back-to-back with out_ready tied 1: three consecutive requests -> each result valid for exactly one cycle, spaced NIB+2=6 cycles apart, with correct sums.

Source files
------------

// File: rtl/cpa_nibble_sequencer_if.sv
// Request/response bundle between a requester and the nibble-serial add/subtract sequencer.
// The requester drives master; the sequencer takes slave.
interface cpa_nibble_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, cin, a, b, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cpa_nibble_sequencer.sv
// WIDTH-bit add/subtract built by feeding one external 4-bit CPA a nibble per clock,
// LSB nibble first, with the inter-nibble carry held in a register.
module cpa_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cpa_nibble_sequencer_if.slave   bus,
    output logic [3:0]              o_cpa_a,
    output logic [3:0]              o_cpa_b,
    output logic                    o_cpa_cin,
    input  logic [3:0]              i_cpa_s,
    input  logic                    i_cpa_cout
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              w_last;

    assign w_last = (r_idx == IDXW'(NIB - 1));

    // Sequencer FSM: latch operands, walk the nibbles through the CPA, hold result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a        <= bus.a;
                        r_b        <= bus.sub ? ~bus.b : bus.b;
                        r_carry    <= bus.sub ? 1'b1 : bus.cin;
                        r_idx      <= '0;
                        r_sum      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[4*r_idx +: 4] <= i_cpa_s;
                    r_carry             <= i_cpa_cout;
                    if (w_last) begin
                        // Overflow judged on the effective B sign, so subtraction needs no special case.
                        r_cout      <= i_cpa_cout;
                        r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (i_cpa_s[3] != r_a[WIDTH-1]);
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // CPA operand steering: only the current nibble during RUN, quiet otherwise.
    always_comb begin
        o_cpa_a   = 4'h0;
        o_cpa_b   = 4'h0;
        o_cpa_cin = 1'b0;
        if (r_state == S_RUN) begin
            o_cpa_a   = r_a[4*r_idx +: 4];
            o_cpa_b   = r_b[4*r_idx +: 4];
            o_cpa_cin = r_carry;
        end else begin
            o_cpa_a   = 4'h0;
            o_cpa_b   = 4'h0;
            o_cpa_cin = 1'b0;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_cpa_nibble_sequencer.sv
// Bench for cpa_nibble_sequencer: arithmetic reference model feeds a scoreboard queue,
// a monitor compares every presented result; directed cases plus randomized operations.
module tb_cpa_nibble_sequencer;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] cpa_a;
    logic [3:0] cpa_b;
    logic       cpa_cin;
    logic [3:0] cpa_s;
    logic       cpa_cout;

    int checks   = 0;
    int failures = 0;
    logic [17:0] exp_q[$];

    cpa_nibble_sequencer_if #(.WIDTH(W)) bus ();

    cpa_nibble_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .o_cpa_a    (cpa_a),
        .o_cpa_b    (cpa_b),
        .o_cpa_cin  (cpa_cin),
        .i_cpa_s    (cpa_s),
        .i_cpa_cout (cpa_cout)
    );

    // The shared external adder
    assign {cpa_cout, cpa_s} = 5'(cpa_a) + 5'(cpa_b) + 5'(cpa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {cout, ovf, sum} from true integer arithmetic
    function automatic logic [17:0] model(input logic s, input logic c,
                                          input logic [15:0] a, input logic [15:0] b);
        int unsigned ua = a;
        int unsigned ub = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int r;
        logic [16:0] full;
        logic ov;
        if (s) begin
            full = 17'(ua + 32'h10000 - ub);
            r    = sa - sb;
        end else begin
            full = 17'(ua + ub + c);
            r    = sa + sb + int'(c);
        end
        ov = (r > 32767) || (r < -32768);
        return {full[16], ov, full[15:0]};
    endfunction

    always @(posedge clk) begin
        if (rst_n && bus.start && bus.in_ready)
            exp_q.push_back(model(bus.sub, bus.cin, bus.a, bus.b));
    end

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {14'h0, bus.cout, bus.ovf, bus.sum}, 32'h3ffff);
            end else begin
                check("result", {14'h0, bus.cout, bus.ovf, bus.sum}, {14'h0, exp_q[0]});
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_before_start", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_op(input logic s, input logic c, input logic [15:0] a,
                          input logic [15:0] b, input int hold, input bit poke);
        logic [15:0] eb;
        logic [17:0] e;
        int unsigned c0;
        int unsigned mask;
        eb = s ? ~b : b;
        c0 = s ? 1 : 32'(c);
        e  = model(s, c, a, b);
        wait_ready();
        bus.start = 1'b1; bus.sub = s; bus.cin = c; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < NIB; k++) begin
            mask = (32'd1 << (4 * k)) - 32'd1;
            check("run_out_valid", 32'(bus.out_valid), 32'd0);
            check("run_in_ready", 32'(bus.in_ready), 32'd0);
            check("cpa_a", 32'(cpa_a), 32'((a >> (4 * k)) & 16'hf));
            check("cpa_b", 32'(cpa_b), 32'((eb >> (4 * k)) & 16'hf));
            check("cpa_cin", 32'(cpa_cin), ((a & mask) + (eb & mask) + c0) >> (4 * k));
            if (poke && k == 1) begin
                bus.start = 1'b1; bus.a = 16'($urandom); bus.b = 16'($urandom); bus.sub = ~s;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        check("latency_out_valid", 32'(bus.out_valid), 32'd1);
        for (int h = 0; h < hold; h++) begin
            check("done_in_ready", 32'(bus.in_ready), 32'd0);
            check("done_cpa_quiet", {23'h0, cpa_a, cpa_b, cpa_cin}, 32'd0);
            if (poke) begin
                bus.start = 1'b1; bus.a = 16'($urandom); bus.b = 16'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            check("held_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
        check("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_hs_result_kept", {14'h0, bus.cout, bus.ovf, bus.sum}, {14'h0, e});
        @(posedge clk); #1;
        check("no_queued_start", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int valid_cyc[$];
        int issued;
        logic [15:0] tab_a[3];
        logic [15:0] tab_b[3];
        tab_a[0] = 16'h1111; tab_b[0] = 16'h2222;
        tab_a[1] = 16'hfff0; tab_b[1] = 16'h0020;
        tab_a[2] = 16'h8000; tab_b[2] = 16'h8000;

        rst_n = 1'b0;
        bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0;
        bus.a = 16'h0; bus.b = 16'h0; bus.out_ready = 1'b0;
        #12;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_result", {14'h0, bus.cout, bus.ovf, bus.sum}, 32'd0);
        check("reset_cpa", {23'h0, cpa_a, cpa_b, cpa_cin}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic cases
        run_op(1'b0, 1'b0, 16'h1234, 16'h4321, 0, 1'b0);
        run_op(1'b0, 1'b0, 16'hffff, 16'h0001, 1, 1'b0);
        run_op(1'b0, 1'b1, 16'hffff, 16'h0000, 0, 1'b0);
        run_op(1'b0, 1'b0, 16'h7fff, 16'h0001, 0, 1'b0);
        run_op(1'b1, 1'b0, 16'h0005, 16'h0007, 0, 1'b0);
        run_op(1'b1, 1'b0, 16'h8000, 16'h0001, 0, 1'b0);
        check("vec_add_5555", 32'(model(1'b0, 1'b0, 16'h1234, 16'h4321)), 32'h05555);

        // Backpressure with ignored requests during RUN and DONE
        run_op(1'b0, 1'b1, 16'h0abc, 16'h1def, 3, 1'b1);

        // Asynchronous reset mid-RUN
        wait_ready();
        bus.start = 1'b1; bus.sub = 1'b0; bus.cin = 1'b0; bus.a = 16'h5a5a; bus.b = 16'h1234;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_cpa", {23'h0, cpa_a, cpa_b, cpa_cin}, 32'd0);
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(1'b1, 1'b0, 16'h0100, 16'h0001, 1, 1'b0);

        // Back-to-back with out_ready tied high
        bus.out_ready = 1'b1;
        issued = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            if (bus.in_ready && issued < 3) begin
                bus.start = 1'b1; bus.sub = 1'b0; bus.cin = 1'b0;
                bus.a = tab_a[issued]; bus.b = tab_b[issued];
                issued++;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.out_valid) valid_cyc.push_back(cyc);
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_result_count", 32'(valid_cyc.size()), 32'd3);
        if (valid_cyc.size() == 3) begin
            check("b2b_spacing_1", 32'(valid_cyc[1] - valid_cyc[0]), 32'(NIB + 2));
            check("b2b_spacing_2", 32'(valid_cyc[2] - valid_cyc[1]), 32'(NIB + 2));
        end

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            run_op(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 2)), 1'($urandom));
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
